// File: rtl/cpu_alu_if.sv
// cpu_alu_if: operand/opcode/flag bus between the register-file read side
// (master) and the registered ALU (slave). Results come back on d/fo.
interface cpu_alu_if;
  logic [7:0] a;   // operand A
  logic [7:0] b;   // operand B, or shift/rotate amount in b[2:0]
  logic [7:0] fi;  // incoming flags: fi[0]=carry-in, fi[7:4] passed through
  logic [6:0] op;  // opcode
  logic [7:0] d;   // registered result
  logic [7:0] fo;  // registered flags {fi[7:4], V, N, Z, C}

  modport master (output a, b, fi, op, input d, fo);
  modport slave  (input a, b, fi, op, output d, fo);
endinterface

// File: rtl/cpu_alu.sv
// cpu_alu: registered 8-bit ALU. Combinational datapath computes the result
// and the C/Z/N/V flags; both are captured on the rising clock edge, giving a
// fixed one-cycle latency with a new operation accepted every cycle.
// Optional feature: define ALU_ROTATE_EN to add ROL (0x21) and ROR (0x41);
// without it those opcodes fall into the pass-through default.
module cpu_alu (
  input  logic         clk,
  input  logic         rst,
  cpu_alu_if.slave     bus
);

  localparam logic [6:0] OP_ADD = 7'h00;
  localparam logic [6:0] OP_ADC = 7'h01;
  localparam logic [6:0] OP_SUB = 7'h02;
  localparam logic [6:0] OP_SBB = 7'h03;
  localparam logic [6:0] OP_AND = 7'h04;
  localparam logic [6:0] OP_OR  = 7'h08;
  localparam logic [6:0] OP_XOR = 7'h10;
  localparam logic [6:0] OP_SHL = 7'h20;
  localparam logic [6:0] OP_SHR = 7'h40;
`ifdef ALU_ROTATE_EN
  localparam logic [6:0] OP_ROL = 7'h21;
  localparam logic [6:0] OP_ROR = 7'h41;
`endif

  logic [7:0] d_q,  d_d;
  logic [7:0] fo_q, fo_d;
  logic       c_flag, v_flag;

  logic [2:0] n;       // shift/rotate amount; b[7:3] deliberately ignored
  logic       cin;     // carry/borrow-in, only honoured by ADC/SBB
  logic [8:0] add9;    // 9-bit sum, bit 8 is carry out
  logic [8:0] sub9;    // 9-bit difference, bit 8 is borrow
  logic [8:0] shl9;    // bit 8 holds the last bit shifted out (0 when n=0)
  logic [8:0] shr9;    // bit 0 holds the last bit shifted out (0 when n=0)
  logic       unused_bits;

  assign n    = bus.b[2:0];
  assign cin  = ((bus.op == OP_ADC) || (bus.op == OP_SBB)) ? bus.fi[0] : 1'b0;
  assign add9 = {1'b0, bus.a} + {1'b0, bus.b} + {8'h00, cin};
  assign sub9 = {1'b0, bus.a} - {1'b0, bus.b} - {8'h00, cin};
  assign shl9 = {1'b0, bus.a} << n;
  assign shr9 = {bus.a, 1'b0} >> n;

  // Flag bits fi[3:1] are recomputed, never forwarded; b[7:3] is don't-care.
  assign unused_bits = ^{bus.fi[3:1], bus.b[7:3]};

`ifdef ALU_ROTATE_EN
  logic [2:0] n_neg;   // (8 - n) mod 8; n=0 yields a|a = a
  logic [7:0] rol8, ror8;
  assign n_neg = 3'd0 - n;
  assign rol8  = (bus.a << n) | (bus.a >> n_neg);
  assign ror8  = (bus.a >> n) | (bus.a << n_neg);
`endif

  // Next result and flags from the current operands and opcode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    d_d    = bus.a;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (bus.op)
      OP_ADD, OP_ADC: begin
        d_d    = add9[7:0];
        c_flag = add9[8];
        v_flag = (bus.a[7] == bus.b[7]) && (add9[7] != bus.a[7]);
      end
      OP_SUB, OP_SBB: begin
        d_d    = sub9[7:0];
        c_flag = sub9[8];
        v_flag = (bus.a[7] != bus.b[7]) && (sub9[7] != bus.a[7]);
      end
      OP_AND: d_d = bus.a & bus.b;
      OP_OR:  d_d = bus.a | bus.b;
      OP_XOR: d_d = bus.a ^ bus.b;
      OP_SHL: begin
        d_d    = shl9[7:0];
        c_flag = shl9[8];
      end
      OP_SHR: begin
        d_d    = shr9[8:1];
        c_flag = shr9[0];
      end
`ifdef ALU_ROTATE_EN
      OP_ROL: begin
        d_d    = rol8;
        c_flag = (n != 3'd0) && rol8[0];
      end
      OP_ROR: begin
        d_d    = ror8;
        c_flag = (n != 3'd0) && ror8[7];
      end
`endif
      default: ;  // pass-through: defaults above already give d=a, C=0, V=0
    endcase
    fo_d = {bus.fi[7:4], v_flag, d_d[7], (d_d == 8'h00), c_flag};
  end

  // Output registers; reset clears them immediately and discards in-flight work.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      d_q  <= 8'h00;
      fo_q <= 8'h00;
    end else begin
      d_q  <= d_d;
      fo_q <= fo_d;
    end
  end

  assign bus.d  = d_q;
  assign bus.fo = fo_q;

endmodule

// File: tb/tb_cpu_alu.sv
// tb_cpu_alu: directed vector table, multi-cycle reset/timing sequences and
// randomized operations checked against an integer-arithmetic reference model.
module tb_cpu_alu;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  cpu_alu_if bus ();

  cpu_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] fi;
    logic [6:0] op;
    logic [7:0] d;
    logic [7:0] fo;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] fi, input logic [6:0] op);
    bus.a  = a;
    bus.b  = b;
    bus.fi = fi;
    bus.op = op;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model from the arithmetic rules; returns {fo, d}.
  function automatic logic [15:0] model(input int a, input int b, input int fi, input int op);
    int n, c, r, sr, sa, sb, cf, vf, zf, nf, fo;
    n  = b % 8;
    c  = fi % 2;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    cf = 0;
    vf = 0;
    case (op)
      0, 1: begin
        if (op == 0) c = 0;
        r  = a + b + c;
        sr = sa + sb + c;
        cf = (r > 255) ? 1 : 0;
        vf = (sr > 127 || sr < -128) ? 1 : 0;
        r  = r % 256;
      end
      2, 3: begin
        if (op == 2) c = 0;
        r  = a - b - c;
        sr = sa - sb - c;
        cf = (r < 0) ? 1 : 0;
        vf = (sr > 127 || sr < -128) ? 1 : 0;
        r  = (r + 512) % 256;
      end
      4:  r = a & b;
      8:  r = a | b;
      16: r = a ^ b;
      32: begin
        r  = (a * (1 << n)) % 256;
        cf = (n > 0) ? (a >> (8 - n)) % 2 : 0;
      end
      64: begin
        r  = a >> n;
        cf = (n > 0) ? (a >> (n - 1)) % 2 : 0;
      end
`ifdef ALU_ROTATE_EN
      33: begin
        r  = ((a * (1 << n)) + (a >> (8 - n))) % 256;
        cf = (n > 0) ? r % 2 : 0;
      end
      65: begin
        r  = ((a >> n) + a * (1 << (8 - n))) % 256;
        cf = (n > 0) ? r / 128 : 0;
      end
`endif
      default: r = a;
    endcase
    zf = (r == 0) ? 1 : 0;
    nf = (r >= 128) ? 1 : 0;
    fo = (fi / 16) * 16 + vf * 8 + nf * 4 + zf * 2 + cf;
    return {fo[7:0], r[7:0]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[$];
    logic [15:0] exp;
    int          op_list[11] = '{0, 1, 2, 3, 4, 8, 16, 32, 64, 33, 65};

    vecs.push_back('{8'h01, 8'd100, 8'h00, 7'h00, 8'h65, 8'h00});
    vecs.push_back('{8'h01, 8'd100, 8'h01, 7'h01, 8'h66, 8'h00});
    vecs.push_back('{8'hFF, 8'h01,  8'h00, 7'h00, 8'h00, 8'h03});
    vecs.push_back('{8'h01, 8'd100, 8'h01, 7'h02, 8'h9D, 8'h05});
    vecs.push_back('{8'h01, 8'd100, 8'h00, 7'h03, 8'h9D, 8'h05});
    vecs.push_back('{8'h01, 8'd100, 8'h01, 7'h03, 8'h9C, 8'h05});
    vecs.push_back('{8'h80, 8'h01,  8'h00, 7'h02, 8'h7F, 8'h08});
    vecs.push_back('{8'h00, 8'hFF,  8'h01, 7'h03, 8'h00, 8'h03});
    vecs.push_back('{8'h7F, 8'h00,  8'h01, 7'h01, 8'h80, 8'h0C});
    vecs.push_back('{8'h01, 8'd100, 8'h00, 7'h04, 8'h00, 8'h02});
    vecs.push_back('{8'h01, 8'd100, 8'h00, 7'h08, 8'h65, 8'h00});
    vecs.push_back('{8'h01, 8'd100, 8'h00, 7'h10, 8'h65, 8'h00});
    vecs.push_back('{8'h01, 8'd100, 8'hF0, 7'h04, 8'h00, 8'hF2});
    vecs.push_back('{8'h01, 8'd100, 8'hF0, 7'h00, 8'h65, 8'hF0});
    vecs.push_back('{8'h01, 8'd100, 8'hF1, 7'h10, 8'h65, 8'hF0});
    vecs.push_back('{8'h01, 8'h02,  8'h00, 7'h20, 8'h04, 8'h00});
    vecs.push_back('{8'h00, 8'h02,  8'h00, 7'h20, 8'h00, 8'h02});
    vecs.push_back('{8'd43, 8'h01,  8'h00, 7'h40, 8'h15, 8'h01});
    vecs.push_back('{8'h81, 8'h08,  8'h01, 7'h20, 8'h81, 8'h04});
    vecs.push_back('{8'h81, 8'h08,  8'h01, 7'h40, 8'h81, 8'h04});
    vecs.push_back('{8'h81, 8'h01,  8'h00, 7'h20, 8'h02, 8'h01});
    vecs.push_back('{8'h81, 8'h07,  8'h00, 7'h20, 8'h80, 8'h04});
    vecs.push_back('{8'h81, 8'h07,  8'h00, 7'h40, 8'h01, 8'h00});
    vecs.push_back('{8'h00, 8'h33,  8'h01, 7'h05, 8'h00, 8'h02});
    vecs.push_back('{8'hFF, 8'h01,  8'h01, 7'h7F, 8'hFF, 8'h04});
`ifdef ALU_ROTATE_EN
    vecs.push_back('{8'h81, 8'h01,  8'h00, 7'h41, 8'hC0, 8'h05});
    vecs.push_back('{8'h81, 8'h01,  8'h00, 7'h21, 8'h03, 8'h01});
    vecs.push_back('{8'h81, 8'h08,  8'h00, 7'h21, 8'h81, 8'h04});
`else
    vecs.push_back('{8'h81, 8'h01,  8'h00, 7'h41, 8'h81, 8'h04});
    vecs.push_back('{8'h81, 8'h01,  8'h00, 7'h21, 8'h81, 8'h04});
`endif

    // Reset asserted at time zero clears outputs before any clock edge.
    rst = 1'b1;
    drive(8'hA5, 8'h5A, 8'hFF, 7'h00);
    #1;
    check("reset d before edge", bus.d, 8'h00);
    check("reset fo before edge", bus.fo, 8'h00);
    step();
    step();
    check("reset d held", bus.d, 8'h00);
    check("reset fo held", bus.fo, 8'h00);

    // Release: outputs stay 0 until the first rising edge, then show the result.
    drive(8'h01, 8'd100, 8'h00, 7'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release d before edge", bus.d, 8'h00);
    step();
    check("release first d", bus.d, 8'h65);
    check("release first fo", bus.fo, 8'h00);

    // Directed table.
    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].fi, vecs[i].op);
      step();
      check($sformatf("vec%0d d", i), bus.d, vecs[i].d);
      check($sformatf("vec%0d fo", i), bus.fo, vecs[i].fo);
    end

    // Inputs changing between edges must not disturb the registered outputs.
    drive(8'hFF, 8'h01, 8'h00, 7'h00);
    step();
    drive(8'h12, 8'h34, 8'hF0, 7'h08);
    #3;
    check("hold d between edges", bus.d, 8'h00);
    check("hold fo between edges", bus.fo, 8'h03);
    step();
    check("next edge d", bus.d, 8'h36);
    check("next edge fo", bus.fo, 8'hF0);

    // Mid-operation reset discards the in-flight result asynchronously.
    drive(8'h80, 8'h80, 8'h00, 7'h00);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid reset d async", bus.d, 8'h00);
    check("mid reset fo async", bus.fo, 8'h00);
    step();
    check("mid reset d held", bus.d, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("after mid reset d", bus.d, 8'h00);
    check("after mid reset fo", bus.fo, 8'h0B);

    // Randomized operations against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ra, rb, rfi;
      logic [6:0] rop;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rfi = 8'($urandom);
      if ($urandom_range(0, 9) < 8) rop = 7'(op_list[$urandom_range(0, 10)]);
      else                          rop = 7'($urandom_range(0, 127));
      exp = model(int'(ra), int'(rb), int'(rfi), int'(rop));
      drive(ra, rb, rfi, rop);
      step();
      check($sformatf("rand%0d op%02h a%02h b%02h fi%02h d", i, rop, ra, rb, rfi), bus.d, exp[7:0]);
      check($sformatf("rand%0d op%02h a%02h b%02h fi%02h fo", i, rop, ra, rb, rfi), bus.fo, exp[15:8]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
